pc_sequencer: RTL and testbench

- Parametrised program-counter unit for the MIPS core.
- Holds the PC register and computes PC+4, the sign-extended and shifted branch target, the J-type target and the jump-register target.
- Selects the next PC, with stall support.
- Adds a circular return-address stack (RAS). The RAS records link addresses on JAL/JALR and checks every JR-return against the popped prediction.

---
 rtl/pc_sequencer.sv | 118 +++++++++++
 tb/tb_pc_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter unit: PC register, next-PC selection (seq/branch/jump/jr) with stall,
// and a circular return-address stack that checks every JR-return against its prediction.
module pc_sequencer #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          RAS_DEPTH = 4,
  parameter int          IMM_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [1:0]       pc_sel,
  input  logic             branch_taken,
  input  logic [IMM_W-1:0] imm,
  input  logic [25:0]      jidx,
  input  logic [XLEN-1:0]  rs_val,
  input  logic             link,
  input  logic             ret,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic [XLEN-1:0]  imm_ext,
  output logic [XLEN-1:0]  pc_target,
  output logic [XLEN-1:0]  ras_top,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_mismatch,
  output logic             misalign_err
);

  localparam int              PW     = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int              CW     = PW + 1;
  localparam logic [XLEN-1:0] RST_PC = XLEN'(RESET_PC);
  localparam logic [XLEN-1:0] FOUR   = XLEN'(4);
  localparam logic [CW-1:0]   DEPTH  = CW'(RAS_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [XLEN-1:0] ras_d [RAS_DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mism_q, mism_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] jr_target;
  logic [PW-1:0]   top_idx;

  assign pc           = pc_q;
  assign pc_plus4     = pc_q + FOUR;
  assign imm_ext      = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  assign pc_target    = pc_plus4 + {imm_ext[XLEN-3:0], 2'b00};
  assign jr_target    = {rs_val[XLEN-1:2], 2'b00};
  assign top_idx      = wptr_q - PW'(1);
  assign ras_empty    = (cnt_q == CW'(0));
  assign ras_full     = (cnt_q == DEPTH);
  assign ras_top      = ras_empty ? XLEN'(0) : ras_q[top_idx];
  assign ras_mismatch = mism_q;
  assign misalign_err = mis_q;

  // Next-state: PC select, RAS pop-then-push, one-cycle flag pulses
  always_comb begin
    pc_d   = pc_q;
    ras_d  = ras_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    mism_d = 1'b0;
    mis_d  = 1'b0;
    if (!stall) begin
      case (pc_sel)
        2'b00:   pc_d = pc_plus4;
        2'b01:   pc_d = branch_taken ? pc_target : pc_plus4;
        2'b10:   pc_d = {pc_plus4[XLEN-1:28], jidx, 2'b00};
        2'b11:   pc_d = jr_target;
        default: pc_d = pc_plus4;
      endcase
      mis_d = (pc_sel == 2'b11) && (rs_val[1:0] != 2'b00);
      if (ret && (pc_sel == 2'b11)) begin
        // Raw rs_val is compared so a misaligned return also counts as mispredicted
        if (ras_empty) begin
          mism_d = 1'b1;
        end else begin
          mism_d = (ras_top != rs_val);
          wptr_d = wptr_q - PW'(1);
          cnt_d  = cnt_q - CW'(1);
        end
      end else begin
        mism_d = 1'b0;
      end
      if (link) begin
        ras_d[wptr_d] = pc_plus4;
        wptr_d        = wptr_d + PW'(1);
        cnt_d         = (cnt_d == DEPTH) ? cnt_d : cnt_d + CW'(1);
      end else begin
        cnt_d = cnt_d;
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RST_PC;
      wptr_q <= '0;
      cnt_q  <= '0;
      mism_q <= 1'b0;
      mis_q  <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      pc_q   <= pc_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      mism_q <= mism_d;
      mis_q  <= mis_d;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= ras_d[i];
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven scoreboard bench for pc_sequencer (XLEN=32, RESET_PC=0x00400000, RAS_DEPTH=4).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [1:0]  pc_sel;
  logic        branch_taken;
  logic [15:0] imm;
  logic [25:0] jidx;
  logic [31:0] rs_val;
  logic        link;
  logic        ret;
  logic [31:0] pc, pc_plus4, imm_ext, pc_target, ras_top;
  logic        ras_empty, ras_full, ras_mismatch, misalign_err;

  int n_checks = 0;
  int n_pass   = 0;

  pc_sequencer #(.XLEN(32), .RESET_PC(32'h0040_0000), .RAS_DEPTH(4), .IMM_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pc_sel(pc_sel), .branch_taken(branch_taken),
    .imm(imm), .jidx(jidx), .rs_val(rs_val), .link(link), .ret(ret),
    .pc(pc), .pc_plus4(pc_plus4), .imm_ext(imm_ext), .pc_target(pc_target),
    .ras_top(ras_top), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_mismatch(ras_mismatch), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [1:0]  sel;
    logic        bt;
    logic [15:0] imm;
    logic [25:0] jidx;
    logic [31:0] rs;
    logic        link;
    logic        ret;
    logic        chk_tgt;
    logic [31:0] e_tgt;
    logic [31:0] e_pc;
    logic [31:0] e_top;
    logic        e_empty;
    logic        e_full;
    logic        e_mism;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic st, input logic [1:0] sel, input logic bt,
                              input logic [15:0] im, input logic [25:0] ji, input logic [31:0] rs,
                              input logic lk, input logic rt, input logic ct, input logic [31:0] et,
                              input logic [31:0] ep, input logic [31:0] etop, input logic ee,
                              input logic ef, input logic emm, input logic emi);
    vec_t v;
    v.stall = st; v.sel = sel; v.bt = bt; v.imm = im; v.jidx = ji; v.rs = rs;
    v.link = lk; v.ret = rt; v.chk_tgt = ct; v.e_tgt = et; v.e_pc = ep; v.e_top = etop;
    v.e_empty = ee; v.e_full = ef; v.e_mism = emm; v.e_mis = emi;
    return v;
  endfunction

  initial begin
    vec_t e;
    rst_n = 1'b0; stall = 1'b1; pc_sel = 2'b00; branch_taken = 1'b0; imm = 16'h0;
    jidx = 26'h0; rs_val = 32'h0; link = 1'b0; ret = 1'b0;

    // sequential fetch
    vecs.push_back(mk(1'b0,2'b00,1'b0,16'h0,26'h0,32'h0,1'b0,1'b0,1'b0,32'h0, 32'h0040_0004,32'h0,1'b1,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,2'b00,1'b0,16'h0,26'h0,32'h0,1'b0,1'b0,1'b0,32'h0, 32'h0040_0008,32'h0,1'b1,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,2'b00,1'b0,16'h0,26'h0,32'h0,1'b0,1'b0,1'b0,32'h0, 32'h0040_000C,32'h0,1'b1,1'b0,1'b0,1'b0));
    // branch taken / not taken from 0x00400010
    vecs.push_back(mk(1'b0,2'b11,1'b0,16'h0,26'h0,32'h0040_0010,1'b0,1'b0,1'b0,32'h0, 32'h0040_0010,32'h0,1'b1,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,2'b01,1'b1,16'hFFFC,26'h0,32'h0,1'b0,1'b0,1'b1,32'h0040_0004, 32'h0040_0004,32'h0,1'b1,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,2'b11,1'b0,16'h0,26'h0,32'h0040_0010,1'b0,1'b0,1'b0,32'h0, 32'h0040_0010,32'h0,1'b1,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,2'b01,1'b0,16'hFFFC,26'h0,32'h0,1'b0,1'b0,1'b1,32'h0040_0004, 32'h0040_0014,32'h0,1'b1,1'b0,1'b0,1'b0));
    // JAL then matching return
    vecs.push_back(mk(1'b0,2'b11,1'b0,16'h0,26'h0,32'h0040_0020,1'b0,1'b0,1'b0,32'h0, 32'h0040_0020,32'h0,1'b1,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,2'b10,1'b0,16'h0,26'h0100040,32'h0,1'b1,1'b0,1'b0,32'h0, 32'h0040_0100,32'h0040_0024,1'b0,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,2'b11,1'b0,16'h0,26'h0,32'h0040_0024,1'b0,1'b1,1'b0,32'h0, 32'h0040_0024,32'h0,1'b1,1'b0,1'b0,1'b0));
    // five pushes A..E (A overwritten)
    vecs.push_back(mk(1'b0,2'b11,1'b0,16'h0,26'h0,32'h0040_1000,1'b1,1'b0,1'b0,32'h0, 32'h0040_1000,32'h0040_0028,1'b0,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,2'b11,1'b0,16'h0,26'h0,32'h0040_2000,1'b1,1'b0,1'b0,32'h0, 32'h0040_2000,32'h0040_1004,1'b0,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,2'b11,1'b0,16'h0,26'h0,32'h0040_3000,1'b1,1'b0,1'b0,32'h0, 32'h0040_3000,32'h0040_2004,1'b0,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,2'b11,1'b0,16'h0,26'h0,32'h0040_4000,1'b1,1'b0,1'b0,32'h0, 32'h0040_4000,32'h0040_3004,1'b0,1'b1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,2'b11,1'b0,16'h0,26'h0,32'h0040_5000,1'b1,1'b0,1'b0,32'h0, 32'h0040_5000,32'h0040_4004,1'b0,1'b1,1'b0,1'b0));
    // pops E, D, C, B, then empty pop
    vecs.push_back(mk(1'b0,2'b11,1'b0,16'h0,26'h0,32'h0040_4004,1'b0,1'b1,1'b0,32'h0, 32'h0040_4004,32'h0040_3004,1'b0,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,2'b11,1'b0,16'h0,26'h0,32'h0040_3004,1'b0,1'b1,1'b0,32'h0, 32'h0040_3004,32'h0040_2004,1'b0,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,2'b11,1'b0,16'h0,26'h0,32'h0040_2004,1'b0,1'b1,1'b0,32'h0, 32'h0040_2004,32'h0040_1004,1'b0,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,2'b11,1'b0,16'h0,26'h0,32'h0040_1004,1'b0,1'b1,1'b0,32'h0, 32'h0040_1004,32'h0,1'b1,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,2'b11,1'b0,16'h0,26'h0,32'h0040_0100,1'b0,1'b1,1'b0,32'h0, 32'h0040_0100,32'h0,1'b1,1'b0,1'b1,1'b0));
    vecs.push_back(mk(1'b0,2'b00,1'b0,16'h0,26'h0,32'h0,1'b0,1'b0,1'b0,32'h0, 32'h0040_0104,32'h0,1'b1,1'b0,1'b0,1'b0));
    // stalled JAL twice, then released
    vecs.push_back(mk(1'b1,2'b10,1'b0,16'h0,26'h0100080,32'h0,1'b1,1'b0,1'b0,32'h0, 32'h0040_0104,32'h0,1'b1,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b1,2'b10,1'b0,16'h0,26'h0100080,32'h0,1'b1,1'b0,1'b0,32'h0, 32'h0040_0104,32'h0,1'b1,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,2'b10,1'b0,16'h0,26'h0100080,32'h0,1'b1,1'b0,1'b0,32'h0, 32'h0040_0200,32'h0040_0108,1'b0,1'b0,1'b0,1'b0));
    // push 0x00400010 then misaligned mismatching return
    vecs.push_back(mk(1'b0,2'b11,1'b0,16'h0,26'h0,32'h0040_000C,1'b0,1'b0,1'b0,32'h0, 32'h0040_000C,32'h0040_0108,1'b0,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,2'b00,1'b0,16'h0,26'h0,32'h0,1'b1,1'b0,1'b0,32'h0, 32'h0040_0010,32'h0040_0010,1'b0,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,2'b11,1'b0,16'h0,26'h0,32'h0040_0013,1'b0,1'b1,1'b0,32'h0, 32'h0040_0010,32'h0040_0108,1'b0,1'b0,1'b1,1'b1));
    vecs.push_back(mk(1'b0,2'b00,1'b0,16'h0,26'h0,32'h0,1'b0,1'b0,1'b0,32'h0, 32'h0040_0014,32'h0040_0108,1'b0,1'b0,1'b0,1'b0));
    // JALR-return: pop matches, push replaces top
    vecs.push_back(mk(1'b0,2'b11,1'b0,16'h0,26'h0,32'h0040_0108,1'b1,1'b1,1'b0,32'h0, 32'h0040_0108,32'h0040_0018,1'b0,1'b0,1'b0,1'b0));
    // ret without jr is ignored
    vecs.push_back(mk(1'b0,2'b00,1'b0,16'h0,26'h0,32'h0,1'b0,1'b1,1'b0,32'h0, 32'h0040_010C,32'h0040_0018,1'b0,1'b0,1'b0,1'b0));

    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", pc, 32'h0040_0000);
    check("reset_empty", {31'h0, ras_empty}, 32'h1);
    check("reset_top", ras_top, 32'h0);
    check("reset_flags", {30'h0, ras_mismatch, misalign_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      stall = vecs[i].stall; pc_sel = vecs[i].sel; branch_taken = vecs[i].bt; imm = vecs[i].imm;
      jidx = vecs[i].jidx; rs_val = vecs[i].rs; link = vecs[i].link; ret = vecs[i].ret;
      exp_q.push_back(vecs[i]);
      if (vecs[i].chk_tgt) begin
        #1;
        check($sformatf("v%0d_target", i), pc_target, vecs[i].e_tgt);
        check($sformatf("v%0d_imm_ext", i), imm_ext, {{16{vecs[i].imm[15]}}, vecs[i].imm});
      end
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("v%0d_pc", i), pc, e.e_pc);
      check($sformatf("v%0d_top", i), ras_top, e.e_top);
      check($sformatf("v%0d_empty", i), {31'h0, ras_empty}, {31'h0, e.e_empty});
      check($sformatf("v%0d_full", i), {31'h0, ras_full}, {31'h0, e.e_full});
      check($sformatf("v%0d_mism", i), {31'h0, ras_mismatch}, {31'h0, e.e_mism});
      check($sformatf("v%0d_misalign", i), {31'h0, misalign_err}, {31'h0, e.e_mis});
    end

    // Async reset mid-stall wipes the pending misalign pulse and the PC
    @(negedge clk);
    stall = 1'b0; pc_sel = 2'b11; rs_val = 32'h0040_0201; link = 1'b0; ret = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_pc", pc, 32'h0040_0200);
    check("pre_rst_misalign", {31'h0, misalign_err}, 32'h1);
    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pc", pc, 32'h0040_0000);
    check("async_rst_misalign", {31'h0, misalign_err}, 32'h0);
    check("async_rst_empty", {31'h0, ras_empty}, 32'h1);
    check("async_rst_top", ras_top, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
